// File: rtl/vga_text_pkg.sv
// Shared types and constants for the VGA text terminal writer.
// Holds screen geometry defaults, control codes, FSM states and cursor ops.
package vga_text_pkg;

    localparam int COLS_DEF = 80;
    localparam int ROWS_DEF = 30;
    localparam int CW       = 10;

    localparam logic [7:0] CC_BS  = 8'h08;
    localparam logic [7:0] CC_LF  = 8'h0A;
    localparam logic [7:0] CC_FF  = 8'h0C;
    localparam logic [7:0] CC_CR  = 8'h0D;
    localparam logic [7:0] CC_DEL = 8'h7F;

    typedef enum logic [2:0] {
        ST_CLEAR,
        ST_IDLE,
        ST_WRITE,
        ST_ERASE,
        ST_CURS
    } state_e;

    typedef enum logic [2:0] {
        OP_NONE,
        OP_INC,
        OP_DEC,
        OP_CR,
        OP_LF,
        OP_HOME
    } cur_op_e;

    function automatic logic is_print(input logic [7:0] b);
        return (b >= 8'h20) && (b != CC_DEL);
    endfunction

    function automatic logic moves_only(input logic [7:0] b);
        return (b == CC_CR) || (b == CC_LF) || (b == CC_BS);
    endfunction

endpackage

// File: rtl/vga_text_cursor.sv
// Screen position register with increment/decrement/CR/LF/home and wrap.
// Used both as the terminal cursor and as the clear-sweep counter.
module vga_text_cursor
    import vga_text_pkg::*;
#(
    parameter int COLS = COLS_DEF,
    parameter int ROWS = ROWS_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  cur_op_e       op,
    output logic [CW-1:0] x,
    output logic [CW-1:0] y
);

    localparam logic [CW-1:0] XMAX = CW'(COLS - 1);
    localparam logic [CW-1:0] YMAX = CW'(ROWS - 1);

    logic [CW-1:0] x_q, x_d;
    logic [CW-1:0] y_q, y_d;
    logic [CW-1:0] y_nxt;

    // Row below the current one, bottom row wraps to the top (no scroll)
    always_comb begin
        y_nxt = (y_q == YMAX) ? '0 : y_q + CW'(1);
    end

    // Next position for the requested operation
    always_comb begin
        x_d = x_q;
        y_d = y_q;
        unique case (op)
            OP_INC: begin
                if (x_q == XMAX) begin
                    x_d = '0;
                    y_d = y_nxt;
                end else begin
                    x_d = x_q + CW'(1);
                end
            end
            OP_DEC: begin
                if (x_q != '0) begin
                    x_d = x_q - CW'(1);
                end else if (y_q != '0) begin
                    x_d = XMAX;
                    y_d = y_q - CW'(1);
                end
            end
            OP_CR: x_d = '0;
            OP_LF: begin
                x_d = '0;
                y_d = y_nxt;
            end
            OP_HOME: begin
                x_d = '0;
                y_d = '0;
            end
            default: ;
        endcase
    end

    // Position register
    always_ff @(posedge clk) begin
        if (rst) begin
            x_q <= '0;
            y_q <= '0;
        end else begin
            x_q <= x_d;
            y_q <= y_d;
        end
    end

    assign x = x_q;
    assign y = y_q;

endmodule

// File: rtl/vga_text_writer.sv
// Terminal front end driving the VGA text-buffer write port.
// Define TERM_CURSOR_EN to draw a visible cursor glyph (ERASE/CURS states).
module vga_text_writer
    import vga_text_pkg::*;
#(
    parameter int         COLS        = COLS_DEF,
    parameter int         ROWS        = ROWS_DEF,
    parameter logic [7:0] CLEAR_CHAR  = 8'd32,
    parameter logic [7:0] CURSOR_CHAR = 8'd95
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic [7:0]    in_data,
    input  logic          in_valid,
    output logic          in_ready,
    output logic          enter,
    output logic [7:0]    data,
    output logic [CW-1:0] dataX,
    output logic [CW-1:0] dataY,
    output logic [CW-1:0] cur_x,
    output logic [CW-1:0] cur_y,
    output logic          busy
);

`ifdef TERM_CURSOR_EN
    localparam state_e ST_DONE  = ST_CURS;
    localparam bit     ERASE_EN = 1'b1;
`else
    localparam state_e ST_DONE  = ST_IDLE;
    localparam bit     ERASE_EN = 1'b0;
`endif

    localparam logic [CW-1:0] XMAX = CW'(COLS - 1);
    localparam logic [CW-1:0] YMAX = CW'(ROWS - 1);

    state_e        state_q, state_d;
    logic [7:0]    cmd_q, cmd_d;
    logic          enter_q, enter_d;
    logic [7:0]    data_q, data_d;
    logic [CW-1:0] dx_q, dx_d;
    logic [CW-1:0] dy_q, dy_d;

    cur_op_e       cop, sop;
    logic [CW-1:0] cx, cy, sx, sy;
    logic [CW-1:0] bs_x, bs_y;
    logic          sweep_last;
    logic          at_home;

    vga_text_cursor #(.COLS(COLS), .ROWS(ROWS)) u_cur (
        .clk (CLK),
        .rst (RST),
        .op  (cop),
        .x   (cx),
        .y   (cy)
    );

    vga_text_cursor #(.COLS(COLS), .ROWS(ROWS)) u_sweep (
        .clk (CLK),
        .rst (RST),
        .op  (sop),
        .x   (sx),
        .y   (sy)
    );

    assign sweep_last = (sx == XMAX) && (sy == YMAX);
    assign at_home    = (cx == '0) && (cy == '0);
    assign bs_x       = (cx != '0) ? cx - CW'(1) : XMAX;
    assign bs_y       = (cx != '0) ? cy : cy - CW'(1);

    // Terminal FSM: sweep, accept, interpret and emit write strobes
    always_comb begin
        state_d = state_q;
        cmd_d   = cmd_q;
        enter_d = 1'b0;
        data_d  = data_q;
        dx_d    = dx_q;
        dy_d    = dy_q;
        cop     = OP_NONE;
        sop     = OP_NONE;
        unique case (state_q)
            ST_CLEAR: begin
                enter_d = 1'b1;
                data_d  = CLEAR_CHAR;
                dx_d    = sx;
                dy_d    = sy;
                sop     = OP_INC;
                if (sweep_last) begin
                    cop     = OP_HOME;
                    state_d = ST_DONE;
                end
            end
            ST_IDLE: begin
                if (in_valid) begin
                    cmd_d   = in_data;
                    state_d = (ERASE_EN && moves_only(in_data))
                            ? ST_ERASE : ST_WRITE;
                end
            end
            ST_ERASE: begin
                enter_d = 1'b1;
                data_d  = CLEAR_CHAR;
                dx_d    = cx;
                dy_d    = cy;
                state_d = ST_WRITE;
            end
            ST_WRITE: begin
                state_d = ST_DONE;
                unique case (1'b1)
                    is_print(cmd_q): begin
                        enter_d = 1'b1;
                        data_d  = cmd_q;
                        dx_d    = cx;
                        dy_d    = cy;
                        cop     = OP_INC;
                    end
                    (cmd_q == CC_CR): cop = OP_CR;
                    (cmd_q == CC_LF): cop = OP_LF;
                    (cmd_q == CC_BS): begin
                        if (!at_home) begin
                            enter_d = 1'b1;
                            data_d  = CLEAR_CHAR;
                            dx_d    = bs_x;
                            dy_d    = bs_y;
                            cop     = OP_DEC;
                        end
                    end
                    (cmd_q == CC_FF): state_d = ST_CLEAR;
                    default: ;
                endcase
            end
            ST_CURS: begin
                enter_d = 1'b1;
                data_d  = CURSOR_CHAR;
                dx_d    = cx;
                dy_d    = cy;
                state_d = ST_IDLE;
            end
            default: state_d = ST_CLEAR;
        endcase
    end

    // State and registered write-port outputs
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= ST_CLEAR;
            cmd_q   <= '0;
            enter_q <= 1'b0;
            data_q  <= '0;
            dx_q    <= '0;
            dy_q    <= '0;
        end else begin
            state_q <= state_d;
            cmd_q   <= cmd_d;
            enter_q <= enter_d;
            data_q  <= data_d;
            dx_q    <= dx_d;
            dy_q    <= dy_d;
        end
    end

    assign in_ready = (state_q == ST_IDLE);
    assign busy     = !in_ready;
    assign enter    = enter_q;
    assign data     = data_q;
    assign dataX    = dx_q;
    assign dataY    = dy_q;
    assign cur_x    = cx;
    assign cur_y    = cy;

endmodule

// File: tb/tb_vga_text_writer.sv
// Self-checking bench for vga_text_writer against a terminal model.
// Honours TERM_CURSOR_EN when the design is built with it.
module tb_vga_text_writer;

    localparam int NC = 80;
    localparam int NR = 30;
`ifdef TERM_CURSOR_EN
    localparam bit CURS_EN = 1'b1;
`else
    localparam bit CURS_EN = 1'b0;
`endif
    localparam int PRINT_CYC = CURS_EN ? 3 : 2;
    localparam int BS_IDX    = CURS_EN ? 1 : 0;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic [7:0] in_data = 8'h00;
    logic       in_valid = 1'b0;
    logic       in_ready, enter, busy;
    logic [7:0] data;
    logic [9:0] dataX, dataY, cur_x, cur_y;

    vga_text_writer dut (
        .CLK      (CLK),
        .RST      (RST),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .enter    (enter),
        .data     (data),
        .dataX    (dataX),
        .dataY    (dataY),
        .cur_x    (cur_x),
        .cur_y    (cur_y),
        .busy     (busy)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    typedef struct {
        int d;
        int x;
        int y;
        int c;
    } wr_t;

    wr_t obs_q[$];
    wr_t exp_q[$];
    wr_t last_q[$];

    always @(negedge CLK) begin
        wr_t w;
        if (enter === 1'b1) begin
            w.d = int'(data);
            w.x = int'(dataX);
            w.y = int'(dataY);
            w.c = cyc;
            obs_q.push_back(w);
        end
    end

    int n_cmp = 0;
    int n_bad = 0;
    int mx = 0;
    int my = 0;
    int acc_cyc;
    bit to_flag;

    function automatic void push_w(input int d, input int x, input int y);
        wr_t w;
        w.d = d;
        w.x = x;
        w.y = y;
        w.c = 0;
        exp_q.push_back(w);
    endfunction

    // Terminal semantics: which cells a byte writes and where the cursor ends
    function automatic void model_cmd(input logic [7:0] b);
        exp_q.delete();
        if (b == 8'h0C) begin
            for (int y = 0; y < NR; y++)
                for (int x = 0; x < NC; x++)
                    push_w(32, x, y);
            mx = 0;
            my = 0;
        end else if (b >= 8'h20 && b != 8'h7F) begin
            push_w(int'(b), mx, my);
            mx++;
            if (mx == NC) begin
                mx = 0;
                my = (my + 1) % NR;
            end
        end else if (b == 8'h0D || b == 8'h0A || b == 8'h08) begin
            if (CURS_EN) push_w(32, mx, my);
            if (b == 8'h0D) begin
                mx = 0;
            end else if (b == 8'h0A) begin
                mx = 0;
                my = (my + 1) % NR;
            end else if (mx > 0) begin
                mx--;
                push_w(32, mx, my);
            end else if (my > 0) begin
                mx = NC - 1;
                my--;
                push_w(32, mx, my);
            end
        end
        if (CURS_EN) push_w(95, mx, my);
    endfunction

    function automatic bit same_writes();
        if (last_q.size() != exp_q.size()) return 1'b0;
        foreach (exp_q[i])
            if (last_q[i].d != exp_q[i].d || last_q[i].x != exp_q[i].x ||
                last_q[i].y != exp_q[i].y)
                return 1'b0;
        return 1'b1;
    endfunction

    // One handshake, then wait for the block to be ready again
    task automatic drive_byte(input logic [7:0] b);
        int k;
        model_cmd(b);
        to_flag = 1'b0;
        @(negedge CLK);
        obs_q.delete();
        in_data  = b;
        in_valid = 1'b1;
        k = 0;
        while (in_ready !== 1'b1 && k < 5000) begin
            @(negedge CLK);
            k++;
        end
        if (k >= 5000) begin
            to_flag  = 1'b1;
            in_valid = 1'b0;
            last_q   = obs_q;
            return;
        end
        @(posedge CLK);
        #1 acc_cyc = cyc;
        @(negedge CLK);
        in_valid = 1'b0;
        in_data  = 8'($urandom);
        k = 0;
        while (in_ready !== 1'b1 && k < 5000) begin
            @(negedge CLK);
            k++;
        end
        #1;
        if (k >= 5000) to_flag = 1'b1;
        last_q = obs_q;
    endtask

    task automatic goto_xy(input int x, input int y);
        drive_byte(8'h0D);
        while (my != y) drive_byte(8'h0A);
        repeat (x) drive_byte(8'h61);
    endtask

    task automatic test_reset();
        int n, bad, gap, k, ex, ey, lx, ly;
        RST = 1'b1;
        repeat (3) @(negedge CLK);
        n_cmp++;
        if (enter !== 1'b0 || data !== 8'd0 || dataX !== 10'd0 ||
            dataY !== 10'd0) begin
            n_bad++;
            $display("FAIL reset_outputs got enter=%b data=%0d x=%0d y=%0d want 0 0 0 0",
                     enter, data, dataX, dataY);
        end
        n_cmp++;
        if (in_ready !== 1'b0 || busy !== 1'b1 || cur_x !== 10'd0 ||
            cur_y !== 10'd0) begin
            n_bad++;
            $display("FAIL reset_state got ready=%b busy=%b cur=(%0d,%0d) want 0 1 (0,0)",
                     in_ready, busy, cur_x, cur_y);
        end
        RST = 1'b0;
        n = 0; bad = 0; gap = 0; k = 0; ex = 0; ey = 0; lx = -1; ly = -1;
        while (n < NC * NR && k < 3000) begin
            @(negedge CLK);
            k++;
            if (enter === 1'b1) begin
                if (int'(data) != 32 || int'(dataX) != ex || int'(dataY) != ey)
                    bad++;
                lx = int'(dataX);
                ly = int'(dataY);
                n++;
                ex++;
                if (ex == NC) begin
                    ex = 0;
                    ey++;
                end
            end else if (n > 0) begin
                gap++;
            end
        end
        n_cmp++;
        if (n != NC * NR || bad != 0 || gap != 0) begin
            n_bad++;
            $display("FAIL reset_sweep got strobes=%0d badcells=%0d gaps=%0d want 2400 0 0",
                     n, bad, gap);
        end
        n_cmp++;
        if (lx != NC - 1 || ly != NR - 1) begin
            n_bad++;
            $display("FAIL reset_sweep_last got (%0d,%0d) want (79,29)", lx, ly);
        end
        if (CURS_EN) begin
            @(negedge CLK);
            n_cmp++;
            if (enter !== 1'b1 || data !== 8'd95 || dataX !== 10'd0 ||
                dataY !== 10'd0) begin
                n_bad++;
                $display("FAIL reset_curs got enter=%b data=%0d (%0d,%0d) want 1 95 (0,0)",
                         enter, data, dataX, dataY);
            end
        end
        n_cmp++;
        if (in_ready !== 1'b1 || busy !== 1'b0 || cur_x !== 10'd0 ||
            cur_y !== 10'd0) begin
            n_bad++;
            $display("FAIL reset_done got ready=%b busy=%b cur=(%0d,%0d) want 1 0 (0,0)",
                     in_ready, busy, cur_x, cur_y);
        end
        mx = 0;
        my = 0;
    endtask

    task automatic test_back_to_back();
        wr_t tq[$];
        int  k, a0, a1, i1;
        model_cmd(8'h48);
        tq = exp_q;
        model_cmd(8'h69);
        foreach (exp_q[i]) tq.push_back(exp_q[i]);
        exp_q = tq;
        @(negedge CLK);
        obs_q.delete();
        in_data  = 8'h48;
        in_valid = 1'b1;
        k = 0;
        while (in_ready !== 1'b1 && k < 100) begin
            @(negedge CLK);
            k++;
        end
        @(posedge CLK);
        #1 a0 = cyc;
        @(negedge CLK);
        in_data = 8'h69;
        while (in_ready !== 1'b1 && k < 200) begin
            @(negedge CLK);
            k++;
        end
        @(posedge CLK);
        #1 a1 = cyc;
        @(negedge CLK);
        in_valid = 1'b0;
        while (in_ready !== 1'b1 && k < 300) begin
            @(negedge CLK);
            k++;
        end
        #1;
        last_q = obs_q;
        n_cmp++;
        if (k >= 200 || a1 - a0 != PRINT_CYC) begin
            n_bad++;
            $display("FAIL b2b_spacing got %0d cycles (wait %0d) want %0d",
                     a1 - a0, k, PRINT_CYC);
        end
        n_cmp++;
        if (!same_writes()) begin
            n_bad++;
            $display("FAIL b2b_writes got %0d strobes want %0d", last_q.size(),
                     exp_q.size());
        end
        i1 = CURS_EN ? 2 : 1;
        n_cmp++;
        if (last_q.size() <= i1 || last_q[0].d != 8'h48 || last_q[0].x != 0 ||
            last_q[0].y != 0 || last_q[0].c != a0 + 1) begin
            n_bad++;
            $display("FAIL b2b_H got n=%0d want data 0x48 at (0,0) one cycle after accept",
                     last_q.size());
        end else begin
            n_cmp++;
            if (last_q[i1].d != 8'h69 || last_q[i1].x != 1 || last_q[i1].y != 0 ||
                last_q[i1].c != a1 + 1) begin
                n_bad++;
                $display("FAIL b2b_i got data=%h (%0d,%0d) cyc=%0d want 69 (1,0) cyc=%0d",
                         last_q[i1].d, last_q[i1].x, last_q[i1].y, last_q[i1].c, a1 + 1);
            end
        end
        n_cmp++;
        if (cur_x !== 10'd2 || cur_y !== 10'd0) begin
            n_bad++;
            $display("FAIL b2b_cur got (%0d,%0d) want (2,0)", cur_x, cur_y);
        end
    endtask

    task automatic test_wrap();
        goto_xy(NC - 1, NR - 1);
        n_cmp++;
        if (cur_x !== 10'd79 || cur_y !== 10'd29) begin
            n_bad++;
            $display("FAIL wrap_setup got (%0d,%0d) want (79,29)", cur_x, cur_y);
        end
        drive_byte(8'h41);
        n_cmp++;
        if (to_flag || !same_writes() || last_q[0].d != 8'h41 ||
            last_q[0].x != 79 || last_q[0].y != 29) begin
            n_bad++;
            $display("FAIL wrap_write got n=%0d timeout=%b want data 0x41 at (79,29)",
                     last_q.size(), to_flag);
        end
        n_cmp++;
        if (cur_x !== 10'd0 || cur_y !== 10'd0) begin
            n_bad++;
            $display("FAIL wrap_cur got (%0d,%0d) want (0,0)", cur_x, cur_y);
        end
    endtask

    task automatic test_bs();
        goto_xy(5, 3);
        drive_byte(8'h08);
        n_cmp++;
        if (to_flag || !same_writes() || last_q[BS_IDX].d != 32 ||
            last_q[BS_IDX].x != 4 || last_q[BS_IDX].y != 3 ||
            cur_x !== 10'd4 || cur_y !== 10'd3) begin
            n_bad++;
            $display("FAIL bs_mid got n=%0d cur=(%0d,%0d) want 32 at (4,3) cur=(4,3)",
                     last_q.size(), cur_x, cur_y);
        end
        goto_xy(0, 3);
        drive_byte(8'h08);
        n_cmp++;
        if (to_flag || !same_writes() || last_q[BS_IDX].d != 32 ||
            last_q[BS_IDX].x != 79 || last_q[BS_IDX].y != 2 ||
            cur_x !== 10'd79 || cur_y !== 10'd2) begin
            n_bad++;
            $display("FAIL bs_rowback got n=%0d cur=(%0d,%0d) want 32 at (79,2) cur=(79,2)",
                     last_q.size(), cur_x, cur_y);
        end
        goto_xy(0, 0);
        drive_byte(8'h08);
        n_cmp++;
        if (to_flag || last_q.size() != (CURS_EN ? 2 : 0) ||
            cur_x !== 10'd0 || cur_y !== 10'd0) begin
            n_bad++;
            $display("FAIL bs_home got strobes=%0d cur=(%0d,%0d) want %0d (0,0)",
                     last_q.size(), cur_x, cur_y, CURS_EN ? 2 : 0);
        end
    endtask

    task automatic test_ctrl();
        goto_xy(7, 4);
        drive_byte(8'h0D);
        n_cmp++;
        if (to_flag || !same_writes() || cur_x !== 10'd0 || cur_y !== 10'd4) begin
            n_bad++;
            $display("FAIL ctrl_cr got strobes=%0d cur=(%0d,%0d) want %0d (0,4)",
                     last_q.size(), cur_x, cur_y, exp_q.size());
        end
        drive_byte(8'h0A);
        n_cmp++;
        if (to_flag || !same_writes() || cur_x !== 10'd0 || cur_y !== 10'd5) begin
            n_bad++;
            $display("FAIL ctrl_lf got strobes=%0d cur=(%0d,%0d) want %0d (0,5)",
                     last_q.size(), cur_x, cur_y, exp_q.size());
        end
        drive_byte(8'h1B);
        n_cmp++;
        if (to_flag || last_q.size() != (CURS_EN ? 1 : 0) ||
            cur_x !== 10'd0 || cur_y !== 10'd5) begin
            n_bad++;
            $display("FAIL ctrl_esc got strobes=%0d cur=(%0d,%0d) want %0d (0,5)",
                     last_q.size(), cur_x, cur_y, CURS_EN ? 1 : 0);
        end
        drive_byte(8'h7F);
        n_cmp++;
        if (to_flag || last_q.size() != (CURS_EN ? 1 : 0) ||
            cur_x !== 10'd0 || cur_y !== 10'd5) begin
            n_bad++;
            $display("FAIL ctrl_del got strobes=%0d cur=(%0d,%0d) want %0d (0,5)",
                     last_q.size(), cur_x, cur_y, CURS_EN ? 1 : 0);
        end
    endtask

    task automatic test_random();
        logic [7:0] b;
        int         r;
        for (int i = 0; i < 300; i++) begin
            r = $urandom_range(0, 9);
            if (r <= 5) begin
                b = 8'($urandom_range(32, 255));
                if (b == 8'h7F) b = 8'h7E;
            end else if (r == 6) begin
                b = 8'h0D;
            end else if (r == 7) begin
                b = 8'h0A;
            end else if (r == 8) begin
                b = 8'h08;
            end else begin
                b = 8'($urandom_range(0, 31));
                if (b == 8'h0C) b = 8'h7F;
            end
            drive_byte(b);
            n_cmp++;
            if (to_flag || !same_writes() || int'(cur_x) != mx ||
                int'(cur_y) != my) begin
                n_bad++;
                $display("FAIL rand[%0d] byte=%h strobes got %0d want %0d cur got (%0d,%0d) want (%0d,%0d)",
                         i, b, last_q.size(), exp_q.size(), cur_x, cur_y, mx, my);
            end
        end
    endtask

    task automatic test_ff_reset();
        int n, bad, gap, k, ex, ey, lx, ly;
        @(negedge CLK);
        in_data  = 8'h0C;
        in_valid = 1'b1;
        k = 0;
        while (in_ready !== 1'b1 && k < 100) begin
            @(negedge CLK);
            k++;
        end
        @(posedge CLK);
        @(negedge CLK);
        in_valid = 1'b0;
        n = 0; bad = 0; k = 0; ex = 0; ey = 0;
        while (n < 1000 && k < 3000) begin
            if (enter === 1'b1) begin
                if (int'(data) != 32 || int'(dataX) != ex || int'(dataY) != ey)
                    bad++;
                n++;
                ex++;
                if (ex == NC) begin
                    ex = 0;
                    ey++;
                end
            end
            if (n < 1000) begin
                @(negedge CLK);
                k++;
            end
        end
        n_cmp++;
        if (n != 1000 || bad != 0) begin
            n_bad++;
            $display("FAIL ff_partial got strobes=%0d badcells=%0d want 1000 0", n, bad);
        end
        RST = 1'b1;
        @(negedge CLK);
        n_cmp++;
        if (enter !== 1'b0 || in_ready !== 1'b0 || cur_x !== 10'd0 ||
            cur_y !== 10'd0) begin
            n_bad++;
            $display("FAIL ff_rst got enter=%b ready=%b cur=(%0d,%0d) want 0 0 (0,0)",
                     enter, in_ready, cur_x, cur_y);
        end
        RST = 1'b0;
        n = 0; bad = 0; gap = 0; k = 0; ex = 0; ey = 0; lx = -1; ly = -1;
        while (n < NC * NR && k < 3000) begin
            @(negedge CLK);
            k++;
            if (enter === 1'b1) begin
                if (int'(data) != 32 || int'(dataX) != ex || int'(dataY) != ey)
                    bad++;
                lx = int'(dataX);
                ly = int'(dataY);
                n++;
                ex++;
                if (ex == NC) begin
                    ex = 0;
                    ey++;
                end
            end else if (n > 0) begin
                gap++;
            end
        end
        n_cmp++;
        if (n != NC * NR || bad != 0 || gap != 0 || lx != NC - 1 || ly != NR - 1) begin
            n_bad++;
            $display("FAIL ff_resweep got strobes=%0d bad=%0d gaps=%0d last=(%0d,%0d) want 2400 0 0 (79,29)",
                     n, bad, gap, lx, ly);
        end
        if (CURS_EN) begin
            @(negedge CLK);
            n_cmp++;
            if (enter !== 1'b1 || data !== 8'd95 || dataX !== 10'd0 ||
                dataY !== 10'd0) begin
                n_bad++;
                $display("FAIL ff_curs got enter=%b data=%0d (%0d,%0d) want 1 95 (0,0)",
                         enter, data, dataX, dataY);
            end
        end
        n_cmp++;
        if (in_ready !== 1'b1 || cur_x !== 10'd0 || cur_y !== 10'd0) begin
            n_bad++;
            $display("FAIL ff_done got ready=%b cur=(%0d,%0d) want 1 (0,0)",
                     in_ready, cur_x, cur_y);
        end
        mx = 0;
        my = 0;
    endtask

    task automatic test_ff_full();
        goto_xy(11, 6);
        drive_byte(8'h0C);
        n_cmp++;
        if (to_flag || !same_writes() || cur_x !== 10'd0 || cur_y !== 10'd0) begin
            n_bad++;
            $display("FAIL ff_full got strobes=%0d cur=(%0d,%0d) want %0d (0,0)",
                     last_q.size(), cur_x, cur_y, exp_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_wrap();
        test_bs();
        test_ctrl();
        test_random();
        test_ff_full();
        test_ff_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
